// File: rtl/upd78xx_muldiv.sv
// Sequential radix-2^BPS multiply/divide engine for the uPD78xx ALU.
// State advances only on CE; results hold in DONE until the next accepted START.
module upd78xx_muldiv #(
   parameter int W   = 8,  // operand width, >= 4
   parameter int BPS = 1   // bits retired per step, must divide W
) (
   input  logic           CLK,
   input  logic           RESETB,
   input  logic           CE,
   input  logic           START,
   input  logic [1:0]     OP,
   input  logic [2*W-1:0] A_I,
   input  logic [W-1:0]   B_I,
   output logic           BUSY,
   output logic           DONE,
   output logic [2*W-1:0] P_O,
   output logic [W-1:0]   R_O,
   output logic           DZ
);

   localparam int NMUL = W / BPS;
   localparam int NDIV = 2 * W / BPS;
   localparam int CW   = $clog2(NDIV + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {OP_MULU = 2'b00, OP_DIVU = 2'b01,
                             OP_MULS = 2'b10, OP_NOP  = 2'b11} op_t;

   state_t         state_q, state_d;
   op_t            op_q, op_d, op_in;
   logic [2*W-1:0] acc_q, acc_d;      // MUL accumulator / DIV dividend-quotient shifter
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [W-1:0]   b_q, b_d;          // MUL multiplier shifter / DIV divisor
   logic [W-1:0]   rem_q, rem_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           neg_q, neg_d, dz_q, dz_d;

   logic           accept, run_step, last_step;
   logic [W-1:0]   a_lo, a_mag, b_mag;
   logic [2*W-1:0] mul_acc, div_q;
   logic [W:0]     div_r;

   assign op_in     = op_t'(OP);
   assign accept    = CE && START && (state_q != S_RUN);
   assign run_step  = CE && (state_q == S_RUN);
   assign last_step = run_step && (cnt_q == CW'(1));

   // MULS works on magnitudes; the product sign is reapplied on the last step.
   assign a_lo  = A_I[W-1:0];
   assign a_mag = (op_in == OP_MULS && a_lo[W-1]) ? -a_lo : a_lo;
   assign b_mag = (op_in == OP_MULS && B_I[W-1])  ? -B_I  : B_I;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (accept) state_d = S_RUN;
         S_RUN:          if (last_step) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      dz_d    = dz_q;

      mul_acc = acc_q;
      for (int i = 0; i < BPS; i++)
         if (b_q[i]) mul_acc = mul_acc + (mcand_q << i);

      div_r = {1'b0, rem_q};
      div_q = acc_q;
      for (int i = 0; i < BPS; i++) begin
         div_r = {div_r[W-1:0], div_q[2*W-1]};
         div_q = {div_q[2*W-2:0], 1'b0};
         if (div_r >= {1'b0, b_q}) begin
            div_r    = div_r - {1'b0, b_q};
            div_q[0] = 1'b1;
         end
      end

      if (accept) begin
         op_d    = op_in;
         acc_d   = '0;
         rem_d   = '0;
         mcand_d = {{W{1'b0}}, a_mag};
         b_d     = B_I;
         neg_d   = 1'b0;
         dz_d    = 1'b0;
         unique case (op_in)
            OP_MULU: cnt_d = CW'(NMUL);
            OP_MULS: begin
               b_d   = b_mag;
               neg_d = a_lo[W-1] ^ B_I[W-1];
               cnt_d = CW'(NMUL);
            end
            OP_DIVU: begin
               if (B_I == '0) begin
                  acc_d = '1;
                  rem_d = a_lo;
                  dz_d  = 1'b1;
                  cnt_d = CW'(1);
               end else begin
                  acc_d = A_I;
                  cnt_d = CW'(NDIV);
               end
            end
            default: cnt_d = CW'(1);
         endcase
      end else if (run_step) begin
         cnt_d = cnt_q - CW'(1);
         unique case (op_q)
            OP_MULU, OP_MULS: begin
               acc_d   = (last_step && neg_q) ? -mul_acc : mul_acc;
               mcand_d = mcand_q << BPS;
               b_d     = b_q >> BPS;
            end
            OP_DIVU: begin
               if (!dz_q) begin
                  acc_d = div_q;
                  rem_d = div_r[W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: datapath registers are reset too, so no partial result outlives a reset.
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         op_q    <= OP_MULU;
         acc_q   <= '0;
         mcand_q <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         op_q    <= op_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         dz_q    <= dz_d;
      end
   end

   assign BUSY = (state_q == S_RUN);
   assign DONE = (state_q == S_DONE);
   assign P_O  = acc_q;
   assign R_O  = rem_q;
   assign DZ   = dz_q;

endmodule

// File: tb/tb_upd78xx_muldiv.sv
// Self-checking bench for upd78xx_muldiv: directed vectors plus randomized ops
// against an arithmetic reference model, for BPS=1 and BPS=2 builds.
module tb_upd78xx_muldiv;

   logic        CLK = 1'b0;
   logic        RESETB;
   logic        CE;
   logic        START;
   logic [1:0]  OP;
   logic [15:0] A_I;
   logic [7:0]  B_I;

   logic        busy1, done1, dz1, busy2, done2, dz2;
   logic [15:0] p1, p2;
   logic [7:0]  r1, r2;

   logic        use2;
   logic        o_busy, o_done, o_dz;
   logic [15:0] o_p;
   logic [7:0]  o_r;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] last_p;

   always #5 CLK = ~CLK;

   upd78xx_muldiv #(.W(8), .BPS(1)) dut (
      .CLK(CLK), .RESETB(RESETB), .CE(CE), .START(START), .OP(OP),
      .A_I(A_I), .B_I(B_I), .BUSY(busy1), .DONE(done1),
      .P_O(p1), .R_O(r1), .DZ(dz1));

   upd78xx_muldiv #(.W(8), .BPS(2)) dut2 (
      .CLK(CLK), .RESETB(RESETB), .CE(CE), .START(START), .OP(OP),
      .A_I(A_I), .B_I(B_I), .BUSY(busy2), .DONE(done2),
      .P_O(p2), .R_O(r2), .DZ(dz2));

   assign o_busy = use2 ? busy2 : busy1;
   assign o_done = use2 ? done2 : done1;
   assign o_p    = use2 ? p2    : p1;
   assign o_r    = use2 ? r2    : r1;
   assign o_dz   = use2 ? dz2   : dz1;

   // Reference model: plain arithmetic on the operation's definition.
   task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                        input int bps, output logic [15:0] p, output logic [7:0] r,
                        output logic dz, output int n);
      int sa, sb;
      dz = 1'b0;
      r  = 8'h00;
      p  = 16'h0000;
      case (op)
         2'b00: begin
            p = 16'(a[7:0]) * 16'(b);
            n = 8 / bps;
         end
         2'b10: begin
            sa = $signed(a[7:0]);
            sb = $signed(b);
            p  = 16'(sa * sb);
            n  = 8 / bps;
         end
         2'b01: begin
            if (b == 8'h00) begin
               p  = 16'hFFFF;
               r  = a[7:0];
               dz = 1'b1;
               n  = 1;
            end else begin
               p = a / 16'(b);
               r = 8'(a % 16'(b));
               n = 16 / bps;
            end
         end
         default: n = 1;
      endcase
   endtask

   task automatic do_reset();
      RESETB = 1'b0;
      CE = 1'b0; START = 1'b0; OP = 2'b00; A_I = '0; B_I = '0;
      repeat (3) @(negedge CLK);
      RESETB = 1'b1;
   endtask

   // Starts one op (called just after a negedge) and waits for DONE.
   task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                         input int ce_period, input bit inject, input string name);
      logic [15:0] ep;
      logic [7:0]  er;
      logic        edz;
      int          n, edges;
      bit          seen;
      model(op, a, b, use2 ? 2 : 1, ep, er, edz, n);
      OP = op; A_I = a; B_I = b; START = 1'b1; CE = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      A_I = 16'($urandom); B_I = 8'($urandom); OP = 2'($urandom);
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL %s start: BUSY/DONE got %b%b expected 10", name, o_busy, o_done);
      end
      if (!edz) begin
         checks++;
         if (o_dz !== 1'b0) begin
            failures++;
            $display("FAIL %s dz_clear: DZ got %b expected 0", name, o_dz);
         end
      end
      edges = 0;
      seen  = 0;
      for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
         CE    = ((cyc % ce_period) == ce_period - 1);
         START = inject && (cyc == 4);
         @(posedge CLK);
         if (CE) edges++;
         @(negedge CLK);
         START = 1'b0;
         checks++;
         if (o_busy && o_done) begin
            failures++;
            $display("FAIL %s exclusive: BUSY and DONE both high", name);
         end
         if (o_done) seen = 1;
         else if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy: BUSY got %b expected 1 before DONE", name, o_busy);
         end
      end
      CE = 1'b1;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s timeout: DONE never rose, expected after %0d CE", name, n);
      end else if (edges != n) begin
         failures++;
         $display("FAIL %s latency: %0d CE edges expected %0d", name, edges, n);
      end
      if (op != 2'b11) begin
         checks++;
         if (o_p !== ep) begin
            failures++;
            $display("FAIL %s P_O: got %h expected %h", name, o_p, ep);
         end
         checks++;
         if (o_r !== er) begin
            failures++;
            $display("FAIL %s R_O: got %h expected %h", name, o_r, er);
         end
      end
      checks++;
      if (o_dz !== edz) begin
         failures++;
         $display("FAIL %s DZ: got %b expected %b", name, o_dz, edz);
      end
      last_p = ep;
   endtask

   task automatic test_reset();
      use2 = 1'b0;
      do_reset();
      checks++;
      if ({busy1, done1, dz1, p1, r1} !== 27'd0 || {busy2, done2, dz2, p2, r2} !== 27'd0) begin
         failures++;
         $display("FAIL reset: outputs got %b%b%b %h %h expected all zero", busy1, done1, dz1, p1, r1);
      end
   endtask

   task automatic test_directed();
      run_op(2'b00, 16'h00FF, 8'hFF, 1, 0, "mulu_ff");
      run_op(2'b01, 16'h1234, 8'h56, 1, 0, "divu_1234");
      run_op(2'b01, 16'hABCD, 8'h00, 1, 0, "divu_zero");
      run_op(2'b10, 16'h0080, 8'h7F, 1, 0, "muls_80_7f");
      run_op(2'b10, 16'h00FF, 8'hFF, 1, 0, "muls_ff_ff");
      run_op(2'b10, 16'h0080, 8'h80, 1, 0, "muls_80_80");
      run_op(2'b11, 16'h1111, 8'h22, 1, 0, "nop");
   endtask

   task automatic test_dz_clear();
      run_op(2'b01, 16'h5555, 8'h00, 2, 0, "dz_set");
      run_op(2'b00, 16'h0003, 8'h05, 1, 0, "dz_then_mul");
   endtask

   task automatic test_ce_gating();
      run_op(2'b01, 16'h1234, 8'h56, 3, 1, "divu_ce3_inject");
   endtask

   task automatic test_persist();
      for (int k = 0; k < 6; k++) begin
         CE = 1'($urandom); START = 1'b0; A_I = 16'($urandom); B_I = 8'($urandom);
         @(posedge CLK);
         @(negedge CLK);
         checks++;
         if (o_done !== 1'b1 || o_p !== last_p) begin
            failures++;
            $display("FAIL persist: DONE %b P_O %h expected 1 %h", o_done, o_p, last_p);
         end
      end
      CE = 1'b1;
   endtask

   task automatic test_random(input int count);
      logic [1:0]  op;
      logic [15:0] a;
      logic [7:0]  b;
      for (int k = 0; k < count; k++) begin
         op = 2'($urandom);
         a  = 16'($urandom);
         b  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         run_op(op, a, b, $urandom_range(1, 3), 0, "random");
      end
   endtask

   task automatic test_reset_midrun();
      OP = 2'b01; A_I = 16'h1234; B_I = 8'h56; START = 1'b1; CE = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      repeat (4) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      RESETB = 1'b0;
      #1;
      checks++;
      if ({busy1, done1, dz1, p1, r1} !== 27'd0) begin
         failures++;
         $display("FAIL reset_midrun: outputs got %b%b%b %h %h expected all zero", busy1, done1, dz1, p1, r1);
      end
      @(negedge CLK);
      RESETB = 1'b1;
      repeat (3) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      checks++;
      if ({busy1, done1, p1, r1} !== 26'd0) begin
         failures++;
         $display("FAIL reset_idle: BUSY/DONE %b%b P_O %h R_O %h expected idle zeros", busy1, done1, p1, r1);
      end
   endtask

   task automatic test_bps2();
      do_reset();
      use2 = 1'b1;
      run_op(2'b00, 16'h00FF, 8'hFF, 1, 0, "bps2_mulu_ff");
      run_op(2'b01, 16'h1234, 8'h56, 1, 0, "bps2_divu");
      run_op(2'b10, 16'h0080, 8'h7F, 1, 0, "bps2_muls");
      test_random(10);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_dz_clear();
      test_ce_gating();
      test_persist();
      test_random(40);
      test_reset_midrun();
      test_bps2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
